// File: rtl/io_command_queue_pkg.sv
// Shared IO definitions for the command queue.
//  - IO_DATA_W       : width of the address and data fields of a command
//  - IO_BASE_ADDR    : first absolute address of the IO window
//  - IO_TOTAL_BYTES  : size of the IO window in bytes
//  - io_cmd_t        : one queued command {minor, addr, data, dest}
//  - addr_in_window  : unsigned, inclusive window test on an absolute address
package io_command_queue_pkg;

  localparam int IO_DATA_W      = 16;
  localparam int IO_BASE_ADDR   = 384;
  localparam int IO_TOTAL_BYTES = 128;

  typedef struct packed {
    logic [3:0]           minor;
    logic [IO_DATA_W-1:0] addr;
    logic [IO_DATA_W-1:0] data;
    logic [3:0]           dest;
  } io_cmd_t;

  // Compare in 32 bits so base+size cannot wrap in the address width.
  function automatic logic addr_in_window(input logic [IO_DATA_W-1:0] a,
                                          input logic [31:0]          base,
                                          input logic [31:0]          size);
    logic [31:0] w_a;
    w_a = 32'(a);
    return (w_a >= base) && (w_a <= (base + size - 32'd1));
  endfunction

endpackage

// File: rtl/io_command_queue_mem.sv
// io_cmd_fifo_mem: DEPTH x io_cmd_t register array, one write port, one
// asynchronous read port. Storage is not reset; validity is tracked by the
// owner of the pointers.
//  i_clk   : clock (rising edge)
//  i_we    : write strobe (already qualified by the caller)
//  i_waddr : write index
//  i_wdata : command written at i_waddr
//  i_raddr : read index
//  o_rdata : command stored at i_raddr
module io_cmd_fifo_mem
  import io_command_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  io_cmd_t                  i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output io_cmd_t                  o_rdata
);

  io_cmd_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/io_command_queue.sv
// io_command_queue: elastic FIFO between the core IO issue port and the IO
// manager command port. Commands outside the IO window are accepted on the
// handshake but dropped, raising a sticky RangeError.
//  sys_clk / clk_en / sync_rst : clock, global enable, sync active-low reset
//  InACK/InREQ + In*           : upstream valid / ready and command fields
//  CommandACK/CommandREQ + *Out: head valid / IO manager accept and head fields
//  Occupancy                   : entry count 0..DEPTH
//  RangeError / ErrorClear     : sticky drop flag and its clear pulse
module io_command_queue
  import io_command_queue_pkg::*;
#(
  parameter int DATABITWIDTH = IO_DATA_W,
  parameter int DEPTH        = 4,
  parameter int IOBASEADDR   = IO_BASE_ADDR,
  parameter int TOTALIOBYTES = IO_TOTAL_BYTES
) (
  input  logic                      sys_clk,
  input  logic                      clk_en,
  input  logic                      sync_rst,
  input  logic                      InACK,
  output logic                      InREQ,
  input  logic [3:0]                InMinorOpcode,
  input  logic [DATABITWIDTH-1:0]   InAddress,
  input  logic [DATABITWIDTH-1:0]   InData,
  input  logic [3:0]                InDestReg,
  output logic                      CommandACK,
  input  logic                      CommandREQ,
  output logic [3:0]                MinorOpcodeOut,
  output logic [DATABITWIDTH-1:0]   CommandAddressOut,
  output logic [DATABITWIDTH-1:0]   CommandDataOut,
  output logic [3:0]                CommandDestReg,
  output logic [$clog2(DEPTH):0]    Occupancy,
  output logic                      RangeError,
  input  logic                      ErrorClear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_range_err;

  logic    w_full, w_empty, w_in_range;
  logic    w_enq_hs, w_wr, w_rd;
  io_cmd_t w_wdata, w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready depends on state only, so a full queue refuses even when the head
  // is leaving in the same cycle.
  assign InREQ      = !w_full;
  assign CommandACK = !w_empty;

  assign w_in_range = addr_in_window(InAddress, 32'(IOBASEADDR), 32'(TOTALIOBYTES));
  assign w_enq_hs   = InACK && InREQ && clk_en;
  assign w_wr       = w_enq_hs && w_in_range;
  assign w_rd       = CommandACK && CommandREQ && clk_en;

  assign w_wdata = '{minor: InMinorOpcode, addr: InAddress, data: InData, dest: InDestReg};

  io_cmd_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .i_clk   (sys_clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  always_ff @(posedge sys_clk) begin
    if (!sync_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_range_err <= 1'b0;
    end else if (clk_en) begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
      // A new drop outranks a clear arriving in the same cycle.
      if (w_enq_hs && !w_in_range) r_range_err <= 1'b1;
      else if (ErrorClear)         r_range_err <= 1'b0;
    end
  end

  assign Occupancy  = r_count;
  assign RangeError = r_range_err;

  // Storage is unreset; mask the head so an empty queue reads as zero.
  assign MinorOpcodeOut    = CommandACK ? w_head.minor : '0;
  assign CommandAddressOut = CommandACK ? w_head.addr  : '0;
  assign CommandDataOut    = CommandACK ? w_head.data  : '0;
  assign CommandDestReg    = CommandACK ? w_head.dest  : '0;

endmodule

// File: tb/tb_io_command_queue.sv
module tb_io_command_queue;
  import io_command_queue_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LO    = 384;
  localparam int HI    = 384 + 128 - 1;

  logic          sys_clk = 1'b0;
  logic          clk_en, sync_rst, InACK, InREQ, CommandACK, CommandREQ;
  logic [3:0]    InMinorOpcode, InDestReg, MinorOpcodeOut, CommandDestReg;
  logic [DW-1:0] InAddress, InData, CommandAddressOut, CommandDataOut;
  logic [2:0]    Occupancy;
  logic          RangeError, ErrorClear;

  always #5 sys_clk = ~sys_clk;

  io_command_queue dut (
    .sys_clk(sys_clk), .clk_en(clk_en), .sync_rst(sync_rst),
    .InACK(InACK), .InREQ(InREQ), .InMinorOpcode(InMinorOpcode),
    .InAddress(InAddress), .InData(InData), .InDestReg(InDestReg),
    .CommandACK(CommandACK), .CommandREQ(CommandREQ),
    .MinorOpcodeOut(MinorOpcodeOut), .CommandAddressOut(CommandAddressOut),
    .CommandDataOut(CommandDataOut), .CommandDestReg(CommandDestReg),
    .Occupancy(Occupancy), .RangeError(RangeError), .ErrorClear(ErrorClear)
  );

  // Reference model: an ordered list of accepted commands plus the flag.
  io_cmd_t q[$];
  logic    m_err = 1'b0;
  int      n_chk = 0;
  int      n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    io_cmd_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".inreq"}, 32'(InREQ),      32'(q.size() != DEPTH));
    chk({tag, ".ack"},   32'(CommandACK), 32'(q.size() != 0));
    chk({tag, ".occ"},   32'(Occupancy),  32'(q.size()));
    chk({tag, ".err"},   32'(RangeError), 32'(m_err));
    chk({tag, ".minor"}, 32'(MinorOpcodeOut),    32'(h.minor));
    chk({tag, ".addr"},  32'(CommandAddressOut), 32'(h.addr));
    chk({tag, ".data"},  32'(CommandDataOut),    32'(h.data));
    chk({tag, ".dest"},  32'(CommandDestReg),    32'(h.dest));
  endtask

  // One clock: decide transfers from pre-edge inputs and model state,
  // then apply them to the model once the edge has passed.
  task automatic tick();
    bit      enq, deq, inr;
    io_cmd_t c;
    enq = InACK && (q.size() != DEPTH);
    deq = CommandREQ && (q.size() != 0);
    inr = (int'(InAddress) >= LO) && (int'(InAddress) <= HI);
    c   = '{minor: InMinorOpcode, addr: InAddress, data: InData, dest: InDestReg};
    @(posedge sys_clk);
    #1;
    if (!sync_rst) begin
      q.delete();
      m_err = 1'b0;
    end else if (clk_en) begin
      if (deq) void'(q.pop_front());
      if (enq && inr) q.push_back(c);
      if (enq && !inr) m_err = 1'b1;
      else if (ErrorClear) m_err = 1'b0;
    end
  endtask

  task automatic drive(input bit ack, input int addr, input int data, input int dest);
    InACK         = ack;
    InAddress     = DW'(addr);
    InData        = DW'(data);
    InDestReg     = 4'(dest);
    InMinorOpcode = 4'($urandom_range(0, 15));
  endtask

  initial begin
    clk_en = 1'b1; sync_rst = 1'b0; CommandREQ = 1'b0; ErrorClear = 1'b0;
    drive(0, 0, 0, 0);
    tick(); tick();
    sync_rst = 1'b1;

    // 1: idle after reset
    repeat (10) begin
      tick();
      check_all("idle");
      chk("idle.occ0", 32'(Occupancy), 0);
    end

    // 2: single entry held until accepted
    drive(1, 384, 16'h00A5, 3);
    tick();
    drive(0, 0, 0, 0);
    check_all("s2");
    chk("s2.ack", 32'(CommandACK), 1);
    chk("s2.addr", 32'(CommandAddressOut), 384);
    chk("s2.data", 32'(CommandDataOut), 32'h00A5);
    chk("s2.dest", 32'(CommandDestReg), 3);
    repeat (3) begin tick(); check_all("s2.hold"); end
    CommandREQ = 1'b1;
    tick();
    CommandREQ = 1'b0;
    check_all("s2.pop");
    chk("s2.ack0", 32'(CommandACK), 0);

    // 3: fill, refuse 5th, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 384 + i * 8, 10 + i, i);
      tick();
      check_all("s3.fill");
    end
    chk("s3.full", 32'(InREQ), 0);
    chk("s3.occ4", 32'(Occupancy), 4);
    drive(1, 400, 16'hBEEF, 9);
    tick();
    drive(0, 0, 0, 0);
    check_all("s3.fifth");
    chk("s3.occ4b", 32'(Occupancy), 4);
    CommandREQ = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_all("s3.drain");
      chk("s3.order", 32'(CommandAddressOut), 32'(384 + i * 8));
      tick();
    end
    CommandREQ = 1'b0;
    check_all("s3.empty");

    // 4: out-of-range drops, clear, set-wins, top bound accepted
    drive(1, 383, 1, 1); tick();
    drive(1, 512, 2, 2); tick();
    drive(0, 0, 0, 0);
    check_all("s4.drop");
    chk("s4.occ0", 32'(Occupancy), 0);
    chk("s4.err1", 32'(RangeError), 1);
    ErrorClear = 1'b1; tick(); ErrorClear = 1'b0;
    chk("s4.clr", 32'(RangeError), 0);
    drive(1, 383, 1, 1); ErrorClear = 1'b1; tick(); ErrorClear = 1'b0;
    drive(0, 0, 0, 0);
    chk("s4.setwins", 32'(RangeError), 1);
    drive(1, 511, 16'h0511, 5); tick();
    drive(0, 0, 0, 0);
    check_all("s4.511");
    chk("s4.occ1", 32'(Occupancy), 1);
    ErrorClear = 1'b1; CommandREQ = 1'b1; tick();
    ErrorClear = 1'b0; CommandREQ = 1'b0;
    check_all("s4.end");

    // 5: steady state at occupancy 2 across pointer wrap
    drive(1, $urandom_range(LO, HI), $urandom, $urandom_range(0, 15)); tick();
    drive(1, $urandom_range(LO, HI), $urandom, $urandom_range(0, 15)); tick();
    CommandREQ = 1'b1;
    repeat (20) begin
      drive(1, $urandom_range(LO, HI), $urandom, $urandom_range(0, 15));
      tick();
      check_all("s5");
      chk("s5.occ2", 32'(Occupancy), 2);
    end
    drive(0, 0, 0, 0);
    tick(); tick();
    CommandREQ = 1'b0;
    check_all("s5.end");

    // 6: clk_en freeze, then reset with 3 entries
    drive(1, 400, 7, 7); tick();
    clk_en = 1'b0; CommandREQ = 1'b1; ErrorClear = 1'b1;
    drive(1, 401, 8, 8);
    repeat (3) begin tick(); check_all("s6.frz"); end
    chk("s6.occ1", 32'(Occupancy), 1);
    clk_en = 1'b1; CommandREQ = 1'b0; ErrorClear = 1'b0;
    drive(1, 402, 9, 9); tick();
    drive(1, 403, 10, 10); tick();
    drive(0, 0, 0, 0);
    chk("s6.occ3", 32'(Occupancy), 3);
    sync_rst = 1'b0; tick(); sync_rst = 1'b1;
    check_all("s6.rst");
    chk("s6.rstocc", 32'(Occupancy), 0);
    chk("s6.rstack", 32'(CommandACK), 0);

    // 7: random traffic against the model
    repeat (400) begin
      clk_en     = ($urandom_range(0, 9) != 0);
      CommandREQ = $urandom_range(0, 1);
      ErrorClear = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 1), $urandom_range(LO - 8, HI + 8), $urandom, $urandom_range(0, 15));
      tick();
      check_all("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
